register_block_arbiter: RTL and testbench

Round-robin arbiter that shares one AXI4-Lite slave (the 4-register `register_block`) between NUM_REQ internal requesters. Each requester issues single-word read/write commands over a simple valid/ready port. The arbiter serialises the commands into AXI4-Lite transactions, one outstanding at a time, and returns the response to the granted requester. It sits between the firmware-side control logic and the S00_AXI port of `register_block`, on the same ACLK/ARESETN domain.

---
 rtl/register_block_arbiter_pkg.sv | 19 +
 rtl/register_block_arbiter_rr_arbiter.sv | 45 ++++
 rtl/register_block_arbiter.sv | 168 ++++++++++++++++
 tb/tb_register_block_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/register_block_arbiter_pkg.sv
// rtl/register_block_arbiter_pkg.sv - shared types and constants for the register block arbiter
package register_block_arbiter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_REQ,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_RESP,
      ST_RESP
   } state_t;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam int ADDR_WIDTH_DEF = 4;
   localparam int DATA_WIDTH_DEF = 32;

endpackage

// File: rtl/register_block_arbiter_rr_arbiter.sv
// rtl/register_block_arbiter_rr_arbiter.sv - round-robin one-hot grant with a registered priority pointer
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   grant_idx
);

   logic [PTR_W-1:0] ptr;

   // Scan from the pointer upward, wrapping; the first requester found wins.
   always_comb begin
      int         idx;
      logic       found;
      logic [PTR_W-1:0] idx_p;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      idx_p     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx   = (int'(ptr) + k) % NUM_REQ;
         idx_p = PTR_W'(idx);
         if (!found && req[idx_p]) begin
            found        = 1'b1;
            grant[idx_p] = 1'b1;
            grant_idx    = idx_p;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (advance) begin
         ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
      end
   end

endmodule

// File: rtl/register_block_arbiter.sv
// rtl/register_block_arbiter.sv - serialises NUM_REQ word commands onto one AXI4-Lite master port
module register_block_arbiter
   import register_block_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic [1:0]                    rsp_resp,
   output logic [ADDR_WIDTH-1:0]         M_AXI_AWADDR,
   output logic                          M_AXI_AWVALID,
   input  logic                          M_AXI_AWREADY,
   output logic [DATA_WIDTH-1:0]         M_AXI_WDATA,
   output logic [DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
   output logic                          M_AXI_WVALID,
   input  logic                          M_AXI_WREADY,
   input  logic [1:0]                    M_AXI_BRESP,
   input  logic                          M_AXI_BVALID,
   output logic                          M_AXI_BREADY,
   output logic [ADDR_WIDTH-1:0]         M_AXI_ARADDR,
   output logic                          M_AXI_ARVALID,
   input  logic                          M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0]         M_AXI_RDATA,
   input  logic [1:0]                    M_AXI_RRESP,
   input  logic                          M_AXI_RVALID,
   output logic                          M_AXI_RREADY
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   state_t                 state, state_d;
   logic [NUM_REQ-1:0]     grant;
   logic [PTR_W-1:0]       grant_idx, owner_q;
   logic                   advance, accept;
   logic                   write_sel;
   logic [ADDR_WIDTH-1:0]  addr_sel, addr_q;
   logic [DATA_WIDTH-1:0]  wdata_sel, wdata_q, rdata_q;
   logic [1:0]             resp_q;
   logic                   aw_pend, w_pend, ar_pend;
   logic                   aw_pend_d, w_pend_d, ar_pend_d;
   logic                   capture_b, capture_r;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_arbiter (
      .clk       (ACLK),
      .rst_n     (ARESETN),
      .req       (req_valid),
      .advance   (advance),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign write_sel = req_write[grant_idx];
   assign addr_sel  = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
   assign wdata_sel = req_wdata[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
   assign accept    = (state == ST_IDLE) && (|grant);

   always_comb begin
      state_d   = state;
      advance   = 1'b0;
      aw_pend_d = aw_pend;
      w_pend_d  = w_pend;
      ar_pend_d = ar_pend;
      capture_b = 1'b0;
      capture_r = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               advance = 1'b1;
               if (write_sel) begin
                  state_d   = ST_WR_REQ;
                  aw_pend_d = 1'b1;
                  w_pend_d  = 1'b1;
               end else begin
                  state_d   = ST_RD_REQ;
                  ar_pend_d = 1'b1;
               end
            end
         end
         // AW and W retire independently; leave once neither is outstanding.
         ST_WR_REQ: begin
            if (M_AXI_AWREADY) aw_pend_d = 1'b0;
            if (M_AXI_WREADY)  w_pend_d  = 1'b0;
            if (!aw_pend_d && !w_pend_d) state_d = ST_WR_RESP;
         end
         ST_WR_RESP: begin
            if (M_AXI_BVALID) begin
               capture_b = 1'b1;
               state_d   = ST_RESP;
            end
         end
         ST_RD_REQ: begin
            if (M_AXI_ARREADY) begin
               ar_pend_d = 1'b0;
               state_d   = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            if (M_AXI_RVALID) begin
               capture_r = 1'b1;
               state_d   = ST_RESP;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state   <= ST_IDLE;
         owner_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         resp_q  <= AXI_RESP_OKAY;
         aw_pend <= 1'b0;
         w_pend  <= 1'b0;
         ar_pend <= 1'b0;
      end else begin
         state   <= state_d;
         aw_pend <= aw_pend_d;
         w_pend  <= w_pend_d;
         ar_pend <= ar_pend_d;
         if (advance) begin
            owner_q <= grant_idx;
            addr_q  <= {addr_sel[ADDR_WIDTH-1:2], 2'b00};
            wdata_q <= write_sel ? wdata_sel : '0;
         end
         if (capture_b) begin
            resp_q  <= M_AXI_BRESP;
            rdata_q <= '0;
         end
         if (capture_r) begin
            resp_q  <= M_AXI_RRESP;
            rdata_q <= M_AXI_RDATA;
         end
      end
   end

   // The accept pulse is combinational, so hold it low while reset is applied.
   assign req_ready     = (accept && ARESETN) ? grant : '0;
   assign rsp_valid     = (state == ST_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
   assign rsp_rdata     = (state == ST_RESP) ? rdata_q : '0;
   assign rsp_resp      = (state == ST_RESP) ? resp_q : AXI_RESP_OKAY;

   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWVALID = aw_pend;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WVALID  = w_pend;
   assign M_AXI_BREADY  = (state == ST_WR_RESP);
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARVALID = ar_pend;
   assign M_AXI_RREADY  = (state == ST_RD_RESP);

endmodule

// File: tb/tb_register_block_arbiter.sv
// tb/tb_register_block_arbiter.sv - randomized self-checking bench with a behavioural arbiter model
module tb_register_block_arbiter;

   localparam int N = 2;

   typedef struct packed {
      logic        write;
      logic [3:0]  addr;
      logic [31:0] wdata;
   } cmd_t;

   logic          ACLK = 1'b0;
   logic          ARESETN = 1'b0;
   logic [N-1:0]  req_valid, req_write, req_ready, rsp_valid;
   logic [N*4-1:0]  req_addr;
   logic [N*32-1:0] req_wdata;
   logic [31:0]   rsp_rdata;
   logic [1:0]    rsp_resp;
   logic [3:0]    M_AXI_AWADDR, M_AXI_ARADDR;
   logic          M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
   logic [31:0]   M_AXI_WDATA, M_AXI_RDATA;
   logic [3:0]    M_AXI_WSTRB;
   logic [1:0]    M_AXI_BRESP, M_AXI_RRESP;
   logic          M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
   logic          M_AXI_RVALID, M_AXI_RREADY;

   always #5 ACLK = ~ACLK;

   register_block_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(4), .DATA_WIDTH(32)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
      .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
      .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
      .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
      .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARVALID(M_AXI_ARVALID),
      .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
      .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
   );

   int checks = 0;
   int passed = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Stimulus controls shared with the driver
   cmd_t req_q [N][$];
   logic issued [N];
   int   slave_mode = 0;   // 0 zero-wait, 1 random, 2 AWREADY late, 3 withhold B
   logic gap_mode = 1'b0;

   // Model state, written only by the monitor
   logic        m_busy = 1'b0, aw_done, w_done, ar_done, rsp_due = 1'b0;
   int          m_ptr = 0, m_owner = 0;
   cmd_t        m_cmd;
   logic [1:0]  m_resp;
   logic [31:0] exp_rdata;
   logic [31:0] m_mem [4];
   int          grant_log [$];
   int          rsp_cnt [N] = '{default: 0};
   logic [31:0] last_rdata_by [N];
   int          last_lat = 0, grant_cyc = 0, cyc = 0, aw_cyc = 0, w_cyc = 0, b_cnt = 0, ready_cnt = 0;
   logic [3:0]  last_awaddr = '0;

   // Requester and AXI slave driver: sample at negedge, drive #1 after posedge
   initial begin : driver
      logic        acc [N];
      logic        awhs, whs, bhs, arhs, rhs, err;
      logic [3:0]  aw_a, ar_a, s_waddr, s_raddr;
      logic [31:0] w_d, s_wdata;
      logic [31:0] s_mem [4];
      logic        aw_got, w_got, r_got;
      int          aw_wait;
      cmd_t        c;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
      M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00; M_AXI_RVALID = 1'b0;
      M_AXI_RRESP = 2'b00; M_AXI_RDATA = '0;
      aw_got = 0; w_got = 0; r_got = 0; aw_wait = 0;
      s_waddr = '0; s_raddr = '0; s_wdata = '0;
      for (int i = 0; i < 4; i++) s_mem[i] = '0;
      for (int i = 0; i < N; i++) issued[i] = 1'b0;
      forever begin
         @(negedge ACLK);
         for (int i = 0; i < N; i++) acc[i] = req_valid[i] && req_ready[i];
         awhs = M_AXI_AWVALID && M_AXI_AWREADY;
         whs  = M_AXI_WVALID && M_AXI_WREADY;
         bhs  = M_AXI_BVALID && M_AXI_BREADY;
         arhs = M_AXI_ARVALID && M_AXI_ARREADY;
         rhs  = M_AXI_RVALID && M_AXI_RREADY;
         aw_a = M_AXI_AWADDR; ar_a = M_AXI_ARADDR; w_d = M_AXI_WDATA;
         if (M_AXI_AWVALID && !awhs) aw_wait++; else aw_wait = 0;
         @(posedge ACLK); #1;
         if (!ARESETN) begin
            aw_got = 0; w_got = 0; r_got = 0; aw_wait = 0;
            M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0;
            for (int i = 0; i < 4; i++) s_mem[i] = '0;
         end else begin
            if (bhs) M_AXI_BVALID = 1'b0;
            if (rhs) M_AXI_RVALID = 1'b0;
            if (awhs) begin aw_got = 1; s_waddr = aw_a; end
            if (whs)  begin w_got = 1;  s_wdata = w_d;  end
            if (arhs) begin r_got = 1;  s_raddr = ar_a; end
            if (aw_got && w_got && !M_AXI_BVALID && slave_mode != 3 &&
                (slave_mode != 1 || $urandom % 2 == 0)) begin
               err = (slave_mode == 1) && ($urandom % 6 == 0);
               if (!err) s_mem[s_waddr[3:2]] = s_wdata;
               M_AXI_BRESP  = err ? 2'b10 : 2'b00;
               M_AXI_BVALID = 1'b1;
               aw_got = 0; w_got = 0;
            end
            if (r_got && !M_AXI_RVALID && (slave_mode != 1 || $urandom % 2 == 0)) begin
               err = (slave_mode == 1) && ($urandom % 6 == 0);
               M_AXI_RDATA  = s_mem[s_raddr[3:2]];
               M_AXI_RRESP  = err ? 2'b11 : 2'b00;
               M_AXI_RVALID = 1'b1;
               r_got = 0;
            end
         end
         case (slave_mode)
            1: begin
               M_AXI_AWREADY = ($urandom % 3 != 0);
               M_AXI_WREADY  = ($urandom % 3 != 0);
               M_AXI_ARREADY = ($urandom % 3 != 0);
            end
            2: begin
               M_AXI_AWREADY = (aw_wait >= 3);
               M_AXI_WREADY  = 1'b1;
               M_AXI_ARREADY = 1'b1;
            end
            default: begin
               M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_ARREADY = 1'b1;
            end
         endcase
         for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
               req_q[i].delete(0);
               issued[i] = 1'b0;
               req_valid[i] = 1'b0;
            end
            if (!issued[i] && req_q[i].size() > 0 && (!gap_mode || $urandom % 2 == 0)) begin
               c = req_q[i][0];
               req_valid[i] = 1'b1;
               req_write[i] = c.write;
               req_addr[i*4 +: 4]   = c.addr;
               req_wdata[i*32 +: 32] = c.wdata;
               issued[i] = 1'b1;
            end
         end
      end
   end

   // Behavioural model and per-cycle comparison
   always @(negedge ACLK) begin : monitor
      logic [N-1:0] exp_ready, exp_rsp;
      logic exp_awv, exp_wv, exp_arv, exp_br, exp_rr;
      int w, idx;
      cyc++;
      ready_cnt += $countones(req_ready);
      if (!ARESETN) begin
         chk("reset_outputs_zero", 32'(|{req_ready, rsp_valid, rsp_rdata, rsp_resp, M_AXI_AWADDR,
             M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARADDR,
             M_AXI_ARVALID, M_AXI_RREADY}), 32'd0);
         chk("reset_wstrb", 32'(M_AXI_WSTRB), 32'hF);
         m_busy = 0; m_ptr = 0; rsp_due = 0;
         aw_done = 0; w_done = 0; ar_done = 0;
         for (int i = 0; i < 4; i++) m_mem[i] = '0;
      end else begin
         exp_ready = '0;
         w = -1;
         if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
               idx = (m_ptr + k) % N;
               if (w < 0 && req_valid[idx]) w = idx;
            end
            if (w >= 0) exp_ready[w] = 1'b1;
         end
         exp_awv = m_busy && m_cmd.write && !aw_done;
         exp_wv  = m_busy && m_cmd.write && !w_done;
         exp_br  = m_busy && m_cmd.write && aw_done && w_done && !rsp_due;
         exp_arv = m_busy && !m_cmd.write && !ar_done;
         exp_rr  = m_busy && !m_cmd.write && ar_done && !rsp_due;
         exp_rsp = '0;
         if (rsp_due) exp_rsp[m_owner] = 1'b1;

         chk("req_ready", 32'(req_ready), 32'(exp_ready));
         chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
         chk("awvalid", 32'(M_AXI_AWVALID), 32'(exp_awv));
         chk("wvalid", 32'(M_AXI_WVALID), 32'(exp_wv));
         chk("bready", 32'(M_AXI_BREADY), 32'(exp_br));
         chk("arvalid", 32'(M_AXI_ARVALID), 32'(exp_arv));
         chk("rready", 32'(M_AXI_RREADY), 32'(exp_rr));
         chk("wstrb", 32'(M_AXI_WSTRB), 32'hF);
         if (exp_awv) chk("awaddr", 32'(M_AXI_AWADDR), 32'(m_cmd.addr));
         if (exp_wv)  chk("wdata", M_AXI_WDATA, m_cmd.wdata);
         if (exp_arv) chk("araddr", 32'(M_AXI_ARADDR), 32'(m_cmd.addr));

         if (rsp_due) begin
            chk("rsp_rdata", rsp_rdata, exp_rdata);
            chk("rsp_resp", 32'(rsp_resp), 32'(m_resp));
            rsp_cnt[m_owner]++;
            last_rdata_by[m_owner] = rsp_rdata;
            last_lat = cyc - grant_cyc;
            rsp_due = 0;
            m_busy = 0;
         end
         if (exp_awv) aw_cyc++;
         if (exp_wv)  w_cyc++;
         if (exp_awv && M_AXI_AWREADY) begin aw_done = 1; last_awaddr = M_AXI_AWADDR; end
         if (exp_wv && M_AXI_WREADY) w_done = 1;
         if (exp_arv && M_AXI_ARREADY) ar_done = 1;
         if (exp_br && M_AXI_BVALID) begin
            rsp_due = 1; m_resp = M_AXI_BRESP; exp_rdata = '0; b_cnt++;
            if (M_AXI_BRESP == 2'b00) m_mem[m_cmd.addr[3:2]] = m_cmd.wdata;
         end
         if (exp_rr && M_AXI_RVALID) begin
            rsp_due = 1; m_resp = M_AXI_RRESP; exp_rdata = m_mem[m_cmd.addr[3:2]];
         end
         if (w >= 0) begin
            m_busy  = 1;
            m_owner = w;
            m_cmd.write = req_write[w];
            m_cmd.addr  = req_addr[w*4 +: 4] & 4'hC;
            m_cmd.wdata = req_wdata[w*32 +: 32];
            m_ptr = (w + 1) % N;
            aw_done = 0; w_done = 0; ar_done = 0;
            aw_cyc = 0; w_cyc = 0;
            grant_log.push_back(w);
            grant_cyc = cyc;
         end
      end
   end

   function automatic cmd_t mk(input logic wr, input logic [3:0] a, input logic [31:0] d);
      mk.write = wr; mk.addr = a; mk.wdata = d;
   endfunction

   task automatic wait_idle(input int max_cyc);
      int k;
      k = 0;
      do begin
         @(negedge ACLK); #1;
         k++;
      end while (k < max_cyc && !(req_q[0].size() == 0 && req_q[1].size() == 0 && !m_busy));
      chk("idle_reached", 32'(k < max_cyc), 32'd1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : test
      int base, r0, r1, rcnt, bc, total;
      repeat (3) @(negedge ACLK);
      @(posedge ACLK); #1 ARESETN = 1'b1;

      // Contention from reset: both writes held together
      req_q[0].push_back(mk(1, 4'h0, 32'h11));
      req_q[1].push_back(mk(1, 4'h8, 32'h22));
      wait_idle(100);
      req_q[0].push_back(mk(0, 4'h0, 32'h0));
      req_q[1].push_back(mk(0, 4'h8, 32'h0));
      wait_idle(100);
      chk("contention_first_grant", 32'(grant_log[0]), 32'd0);
      chk("contention_second_grant", 32'(grant_log[1]), 32'd1);
      chk("readback_req0", last_rdata_by[0], 32'h11);
      chk("readback_req1", last_rdata_by[1], 32'h22);

      // Single write then read, zero-wait latency
      rcnt = ready_cnt;
      req_q[0].push_back(mk(1, 4'h4, 32'h0000_00A5));
      wait_idle(100);
      chk("write_latency", 32'(last_lat), 32'd3);
      req_q[0].push_back(mk(0, 4'h4, 32'h0));
      wait_idle(100);
      chk("read_latency", 32'(last_lat), 32'd3);
      chk("read_a5_data", last_rdata_by[0], 32'h0000_00A5);
      chk("ready_pulses", 32'(ready_cnt - rcnt), 32'd2);

      // Unaligned write is word aligned
      req_q[1].push_back(mk(1, 4'h6, 32'h66));
      wait_idle(100);
      chk("unaligned_awaddr", 32'(last_awaddr), 32'h4);
      req_q[1].push_back(mk(0, 4'h4, 32'h0));
      wait_idle(100);
      chk("unaligned_readback", last_rdata_by[1], 32'h66);

      // AWREADY held off, WREADY immediate
      slave_mode = 2;
      bc = b_cnt;
      req_q[0].push_back(mk(1, 4'hC, 32'h77));
      wait_idle(100);
      chk("bp_aw_cycles", 32'(aw_cyc), 32'd4);
      chk("bp_w_cycles", 32'(w_cyc), 32'd1);
      chk("bp_one_b", 32'(b_cnt - bc), 32'd1);
      slave_mode = 0;

      // Fairness: six back-to-back reads per requester
      base = grant_log.size();
      r0 = rsp_cnt[0]; r1 = rsp_cnt[1];
      for (int k = 0; k < 6; k++) begin
         req_q[0].push_back(mk(0, 4'(k * 4), 32'h0));
         req_q[1].push_back(mk(0, 4'(k * 4 + 1), 32'h0));
      end
      wait_idle(300);
      for (int k = 0; k < 12; k++)
         chk("fair_grant_order", 32'(grant_log[base + k]), 32'((k % 2 == 0) ? 1 : 0));
      chk("fair_rsp0", 32'(rsp_cnt[0] - r0), 32'd6);
      chk("fair_rsp1", 32'(rsp_cnt[1] - r1), 32'd6);

      // Randomized traffic with random slave timing and error responses
      slave_mode = 1;
      gap_mode = 1'b1;
      for (int k = 0; k < 40; k++) begin
         for (int i = 0; i < N; i++)
            req_q[i].push_back(mk(1'($urandom % 2), 4'($urandom), $urandom));
      end
      wait_idle(6000);
      gap_mode = 1'b0;
      slave_mode = 3;

      // Reset while waiting for B aborts the transaction
      total = rsp_cnt[0] + rsp_cnt[1];
      req_q[0].push_back(mk(1, 4'h4, 32'h99));
      for (int k = 0; k < 50 && !M_AXI_BREADY; k++) @(negedge ACLK);
      chk("reached_wr_resp", 32'(M_AXI_BREADY), 32'd1);
      #2 ARESETN = 1'b0;
      #1;
      chk("abort_awvalid_bready", 32'({M_AXI_AWVALID, M_AXI_BREADY, M_AXI_ARVALID}), 32'd0);
      chk("abort_awaddr", 32'(M_AXI_AWADDR), 32'd0);
      repeat (2) @(negedge ACLK);
      @(posedge ACLK); #1 ARESETN = 1'b1;
      slave_mode = 0;
      chk("abort_no_rsp", 32'(rsp_cnt[0] + rsp_cnt[1]), 32'(total));
      r0 = rsp_cnt[0];
      req_q[0].push_back(mk(0, 4'h4, 32'h0));
      wait_idle(100);
      chk("post_reset_rsp", 32'(rsp_cnt[0] - r0), 32'd1);
      chk("post_reset_data", last_rdata_by[0], 32'h0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
